multicycle_control_fsm: RTL and testbench

Multi-cycle successor to the single-cycle RV32I decoder. It sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states and drives the datapath strobes per state. It adds valid/ack handshakes to the instruction and data memories, BNE support, I-type logic ops, a wait timeout, sticky fault flags and a retired-instruction counter. It sits between the instruction register/ALU zero flag and the multi-cycle datapath.

---
 rtl/multicycle_control_fsm.sv | 259 +++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Control unit for the multi-cycle RV32I datapath. Each instruction moves
// through FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The unit raises the
// datapath strobes that belong to each state, handshakes with the
// instruction and data memories, and counts retired instructions. An
// undecodable instruction or a memory that never acknowledges parks the FSM
// in TRAP with a sticky flag set. Only reset leaves TRAP.
//
// Ports
//   clk, rst_n        clock and asynchronous active-low reset
//   run               start/continue enable, sampled in IDLE and at retire
//   opcode/funct3/7   instruction register fields
//   alu_zero          ALU result==0, used by branches in EXEC
//   imem_ack          instruction memory data valid
//   dmem_ack          data memory access complete
//   imem_req, ir_load instruction fetch request / IR capture
//   dmem_req, dmem_we data memory request / write qualifier
//   reg_write         register file write enable
//   mem_to_reg        writeback source (00 ALU, 01 memory, 10 PC+4)
//   alu_src, alu_ctrl ALU operand-B select and operation
//   pc_write, pc_src  PC update strobe and next-PC select
//   retire, instret   retire pulse and retired-instruction count
//   illegal, timeout  sticky fault flags
//   state             debug view of the FSM state
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int ALUCTL_W = 3,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic                alu_zero,
    input  logic                imem_ack,
    input  logic                dmem_ack,
    output logic                imem_req,
    output logic                ir_load,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic                reg_write,
    output logic [1:0]          mem_to_reg,
    output logic                alu_src,
    output logic [ALUCTL_W-1:0] alu_ctrl,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                retire,
    output logic [CNT_W-1:0]    instret,
    output logic                illegal,
    output logic                timeout,
    output logic [2:0]          state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [2:0] C_R      = 3'd0;
    localparam logic [2:0] C_I      = 3'd1;
    localparam logic [2:0] C_LOAD   = 3'd2;
    localparam logic [2:0] C_STORE  = 3'd3;
    localparam logic [2:0] C_BRANCH = 3'd4;
    localparam logic [2:0] C_JAL    = 3'd5;
    localparam logic [2:0] C_JALR   = 3'd6;

    localparam logic [2:0] A_ADD = 3'd0;
    localparam logic [2:0] A_SUB = 3'd1;
    localparam logic [2:0] A_AND = 3'd2;
    localparam logic [2:0] A_OR  = 3'd3;
    localparam logic [2:0] A_XOR = 3'd4;

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

    logic [2:0] state_q, next_state;
    logic [2:0] cls_q, alu_q;
    logic       bne_q;
    logic [7:0] wait_cnt;
    logic       dec_legal, dec_bne;
    logic [2:0] dec_cls, dec_alu;
    logic [2:0] alu_code;
    logic       at_limit, taken;

    assign state    = state_q;
    assign at_limit = (wait_cnt == WAIT_LIMIT);
    // BNE inverts the sense of alu_zero; the flag was captured in DECODE.
    assign taken    = bne_q ? ~alu_zero : alu_zero;

    // Classify the IR contents. Only consumed in DECODE, where the result is
    // latched, so IR changes later in the instruction cannot disturb strobes.
    always_comb begin
        dec_legal = 1'b0;
        dec_cls   = C_R;
        dec_alu   = A_ADD;
        dec_bne   = funct3[0];
        case (opcode)
            7'b0110011: begin
                dec_cls = C_R;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000: begin dec_legal = 1'b1; dec_alu = A_ADD; end
                        3'b111: begin dec_legal = 1'b1; dec_alu = A_AND; end
                        3'b110: begin dec_legal = 1'b1; dec_alu = A_OR;  end
                        3'b100: begin dec_legal = 1'b1; dec_alu = A_XOR; end
                        default: dec_legal = 1'b0;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_alu   = A_SUB;
                end
            end
            7'b0010011: begin
                dec_cls = C_I;
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_alu = A_ADD; end
                    3'b111: begin dec_legal = 1'b1; dec_alu = A_AND; end
                    3'b110: begin dec_legal = 1'b1; dec_alu = A_OR;  end
                    3'b100: begin dec_legal = 1'b1; dec_alu = A_XOR; end
                    default: dec_legal = 1'b0;
                endcase
            end
            7'b0000011: begin dec_legal = 1'b1; dec_cls = C_LOAD;  end
            7'b0100011: begin dec_legal = 1'b1; dec_cls = C_STORE; end
            7'b1100011: begin
                dec_cls   = C_BRANCH;
                dec_alu   = A_SUB;
                dec_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
            end
            7'b1101111: begin dec_legal = 1'b1; dec_cls = C_JAL; end
            7'b1100111: begin
                dec_cls   = C_JALR;
                dec_legal = (funct3 == 3'b000);
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Strobes and next state come from the state register and the latched
    // class only (plus the handshake inputs), never from the live IR.
    always_comb begin
        next_state = state_q;
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 2'b00;
        alu_src    = 1'b0;
        alu_code   = A_ADD;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        retire     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) next_state = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load    = 1'b1;
                    next_state = S_DECODE;
                end else if (at_limit) begin
                    next_state = S_TRAP;
                end
            end
            S_DECODE: begin
                next_state = dec_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                alu_code = alu_q;
                alu_src  = (cls_q != C_R) && (cls_q != C_BRANCH);
                case (cls_q)
                    C_BRANCH: begin
                        pc_write = 1'b1;
                        pc_src   = taken ? 2'b01 : 2'b00;
                        retire   = 1'b1;
                    end
                    C_LOAD, C_STORE: next_state = S_MEM;
                    default:         next_state = S_WB;
                endcase
            end
            S_MEM: begin
                alu_code = alu_q;
                alu_src  = 1'b1;
                dmem_req = 1'b1;
                dmem_we  = (cls_q == C_STORE);
                if (dmem_ack) begin
                    if (cls_q == C_STORE) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end else begin
                        next_state = S_WB;
                    end
                end else if (at_limit) begin
                    next_state = S_TRAP;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                retire    = 1'b1;
                case (cls_q)
                    C_LOAD:  mem_to_reg = 2'b01;
                    C_JAL:   begin mem_to_reg = 2'b10; pc_src = 2'b10; end
                    C_JALR:  begin mem_to_reg = 2'b10; pc_src = 2'b11; end
                    default: mem_to_reg = 2'b00;
                endcase
            end
            S_TRAP:  next_state = S_TRAP;
            default: next_state = S_IDLE;
        endcase
        if (retire) next_state = run ? S_FETCH : S_IDLE;
    end

    always_comb begin
        alu_ctrl      = '0;
        alu_ctrl[2:0] = alu_code;
    end

    // State, decode latch, wait counter, sticky flags and retire counter.
    // The wait counter restarts on every state change, so it measures the
    // time spent in the current FETCH or MEM visit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cls_q    <= C_R;
            alu_q    <= A_ADD;
            bne_q    <= 1'b0;
            wait_cnt <= '0;
            instret  <= '0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state_q <= next_state;
            if (state_q == S_DECODE) begin
                cls_q <= dec_cls;
                alu_q <= dec_alu;
                bne_q <= dec_bne;
                if (!dec_legal) illegal <= 1'b1;
            end
            if (state_q != next_state)
                wait_cnt <= '0;
            else if (state_q == S_FETCH || state_q == S_MEM)
                wait_cnt <= wait_cnt + 8'd1;
            if ((state_q == S_FETCH || state_q == S_MEM) && next_state == S_TRAP)
                timeout <= 1'b1;
            if (retire) instret <= instret + 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Directed bench for multicycle_control_fsm with default parameters
// (ALUCTL_W=3, MAX_WAIT=16, CNT_W=32). Inputs change and outputs are sampled
// one time unit after the falling clock edge, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        alu_zero;
    logic        imem_ack;
    logic        dmem_ack;
    logic        imem_req;
    logic        ir_load;
    logic        dmem_req;
    logic        dmem_we;
    logic        reg_write;
    logic [1:0]  mem_to_reg;
    logic        alu_src;
    logic [2:0]  alu_ctrl;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        retire;
    logic [31:0] instret;
    logic        illegal;
    logic        timeout;
    logic [2:0]  state;

    int assertCount;
    int failCount;

    // Strobe bundle order: imem_req ir_load dmem_req dmem_we reg_write pc_write retire
    localparam logic [6:0] NONE      = 7'b0000000;
    localparam logic [6:0] FETCH_ACK = 7'b1100000;
    localparam logic [6:0] FETCH_REQ = 7'b1000000;
    localparam logic [6:0] WB_STB    = 7'b0000111;
    localparam logic [6:0] BR_STB    = 7'b0000011;
    localparam logic [6:0] MEM_RD    = 7'b0010000;
    localparam logic [6:0] MEM_ST    = 7'b0011011;

    multicycle_control_fsm #(
        .ALUCTL_W(3),
        .MAX_WAIT(16),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .run(run),
        .opcode(opcode),
        .funct3(funct3),
        .funct7(funct7),
        .alu_zero(alu_zero),
        .imem_ack(imem_ack),
        .dmem_ack(dmem_ack),
        .imem_req(imem_req),
        .ir_load(ir_load),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .reg_write(reg_write),
        .mem_to_reg(mem_to_reg),
        .alu_src(alu_src),
        .alu_ctrl(alu_ctrl),
        .pc_write(pc_write),
        .pc_src(pc_src),
        .retire(retire),
        .instret(instret),
        .illegal(illegal),
        .timeout(timeout),
        .state(state)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required end of sequence");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic r, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic z, input logic ia,
                                 input logic da);
        run      = r;
        opcode   = op;
        funct3   = f3;
        funct7   = f7;
        alu_zero = z;
        imem_ack = ia;
        dmem_ack = da;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {imem_req, ir_load, dmem_req, dmem_we, reg_write, pc_write, retire};
    endfunction

    task automatic checkState(input string tag, input logic [2:0] expState,
                              input logic [6:0] expStrobes);
        checkOutput({tag, ".state"}, 64'(state), 64'(expState));
        checkOutput({tag, ".strobes"}, 64'(strobes()), 64'(expStrobes));
    endtask

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    // Linear directed sequence; every step runs in the cycle after the
    // preceding nextCycle, with inputs set before the checks of that cycle.
    initial begin
        assertCount = 0;
        failCount   = 0;
        rst_n = 1'b0;
        applyStimulus(1'b0, 7'd0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checkState("reset", 3'd0, NONE);
        checkOutput("reset.instret", 64'(instret), 64'd0);
        checkOutput("reset.flags", 64'({illegal, timeout}), 64'd0);
        checkOutput("reset.alu_ctrl", 64'(alu_ctrl), 64'd0);

        // ADD with zero-wait memories: states 1,2,3,5, retire in cycle 4.
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(1'b1, 7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b1, 1'b1);
        #1;
        checkState("add.idle", 3'd0, NONE);
        nextCycle();
        checkState("add.fetch", 3'd1, FETCH_ACK);
        nextCycle();
        checkState("add.decode", 3'd2, NONE);
        nextCycle();
        checkState("add.exec", 3'd3, NONE);
        checkOutput("add.alu", 64'({alu_ctrl, alu_src}), 64'({3'b000, 1'b0}));
        nextCycle();
        run = 1'b0;
        #1;
        checkState("add.wb", 3'd5, WB_STB);
        checkOutput("add.wb.sel", 64'({mem_to_reg, pc_src}), 64'({2'b00, 2'b00}));
        nextCycle();
        checkState("add.after", 3'd0, NONE);
        checkOutput("add.instret", 64'(instret), 64'd1);

        // LOAD with dmem_ack three cycles late: MEM for 4 cycles, retire in cycle 8.
        applyStimulus(1'b1, 7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b1, 1'b0);
        nextCycle();
        checkState("ld.fetch", 3'd1, FETCH_ACK);
        nextCycle();
        checkState("ld.decode", 3'd2, NONE);
        nextCycle();
        checkState("ld.exec", 3'd3, NONE);
        checkOutput("ld.exec.alu", 64'({alu_ctrl, alu_src}), 64'({3'b000, 1'b1}));
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            if (i == 3) dmem_ack = 1'b1;
            #1;
            checkState($sformatf("ld.mem%0d", i), 3'd4, MEM_RD);
        end
        nextCycle();
        run = 1'b0;
        #1;
        checkState("ld.wb", 3'd5, WB_STB);
        checkOutput("ld.wb.mem_to_reg", 64'(mem_to_reg), 64'(2'b01));
        nextCycle();
        checkOutput("ld.instret", 64'(instret), 64'd2);

        // BNE, alu_zero=0 (taken) then alu_zero=1 (not taken), back to back.
        applyStimulus(1'b1, 7'b1100011, 3'b001, 7'b0000000, 1'b0, 1'b1, 1'b1);
        nextCycle();
        checkState("bne1.fetch", 3'd1, FETCH_ACK);
        nextCycle();
        nextCycle();
        checkState("bne1.exec", 3'd3, BR_STB);
        checkOutput("bne1.ctl", 64'({alu_ctrl, alu_src, pc_src}), 64'({3'b001, 1'b0, 2'b01}));
        alu_zero = 1'b1;
        nextCycle();
        checkState("bne2.fetch", 3'd1, FETCH_ACK);
        checkOutput("bne1.instret", 64'(instret), 64'd3);
        nextCycle();
        nextCycle();
        run = 1'b0;
        #1;
        checkState("bne2.exec", 3'd3, BR_STB);
        checkOutput("bne2.pc_src", 64'(pc_src), 64'(2'b00));
        nextCycle();
        checkState("bne2.after", 3'd0, NONE);
        checkOutput("bne2.instret", 64'(instret), 64'd4);

        // Illegal opcode (SYSTEM): TRAP, no writes, instret unchanged.
        applyStimulus(1'b1, 7'b1110011, 3'b000, 7'b0000000, 1'b0, 1'b1, 1'b1);
        nextCycle();
        nextCycle();
        checkState("ill.decode", 3'd2, NONE);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkState($sformatf("ill.trap%0d", i), 3'd6, NONE);
        end
        checkOutput("ill.flags", 64'({illegal, timeout}), 64'({1'b1, 1'b0}));
        checkOutput("ill.instret", 64'(instret), 64'd4);
        rst_n = 1'b0;
        #1;
        checkOutput("ill.reset", 64'({state, illegal, instret}), 64'd0);

        // imem_ack never arrives: 16 FETCH cycles, then TRAP with timeout.
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(1'b1, 7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            nextCycle();
            checkState($sformatf("to.fetch%0d", i), 3'd1, FETCH_REQ);
        end
        nextCycle();
        checkState("to.trap", 3'd6, NONE);
        checkOutput("to.flags", 64'({illegal, timeout}), 64'({1'b0, 1'b1}));
        imem_ack = 1'b1;
        nextCycle();
        checkState("to.trap.ack", 3'd6, NONE);
        rst_n = 1'b0;
        #1;
        checkOutput("to.reset", 64'({state, timeout}), 64'd0);

        // Ack in the 16th (limit) FETCH cycle wins; OR completes normally.
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(1'b1, 7'b0110011, 3'b110, 7'b0000000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            nextCycle();
            if (i == 15) imem_ack = 1'b1;
        end
        #1;
        checkState("lim.fetch", 3'd1, FETCH_ACK);
        nextCycle();
        checkState("lim.decode", 3'd2, NONE);
        checkOutput("lim.timeout", 64'(timeout), 64'd0);
        nextCycle();
        checkOutput("lim.exec.alu", 64'(alu_ctrl), 64'(3'b011));
        nextCycle();
        run = 1'b0;
        #1;
        checkState("lim.wb", 3'd5, WB_STB);
        nextCycle();
        checkOutput("lim.instret", 64'(instret), 64'd1);

        // STORE with run dropped in MEM: store completes, then IDLE.
        applyStimulus(1'b1, 7'b0100011, 3'b010, 7'b0000000, 1'b0, 1'b1, 1'b1);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("st.exec.alu", 64'({state, alu_ctrl, alu_src}), 64'({3'd3, 3'b000, 1'b1}));
        nextCycle();
        run = 1'b0;
        #1;
        checkState("st.mem", 3'd4, MEM_ST);
        checkOutput("st.pc_src", 64'(pc_src), 64'(2'b00));
        nextCycle();
        checkState("st.after", 3'd0, NONE);
        checkOutput("st.instret", 64'(instret), 64'd2);

        // JAL: WB selects PC+4 for the register and the JAL target for the PC.
        applyStimulus(1'b1, 7'b1101111, 3'b000, 7'b0000000, 1'b0, 1'b1, 1'b1);
        nextCycle();
        nextCycle();
        nextCycle();
        nextCycle();
        run = 1'b0;
        #1;
        checkState("jal.wb", 3'd5, WB_STB);
        checkOutput("jal.wb.sel", 64'({mem_to_reg, pc_src}), 64'({2'b10, 2'b10}));
        nextCycle();

        // XORI, reset pulse in WB: reg_write drops at once, instret clears.
        applyStimulus(1'b1, 7'b0010011, 3'b100, 7'b0000000, 1'b0, 1'b1, 1'b1);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("xori.exec.alu", 64'({alu_ctrl, alu_src}), 64'({3'b100, 1'b1}));
        nextCycle();
        checkState("xori.wb", 3'd5, WB_STB);
        checkOutput("xori.instret", 64'(instret), 64'd3);
        rst_n = 1'b0;
        #1;
        checkState("xori.reset", 3'd0, NONE);
        checkOutput("xori.reset.instret", 64'(instret), 64'd0);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
